// File: rtl/aluctr_unit.sv
// ALU control decoder: maps the main-control operation class and the
// instruction funct field to a 3-bit ALU operation select.
// The decode is purely combinational and registered once, so both outputs
// show the decode of the inputs sampled at the previous rising edge.
// func[5:4] do not take part in the decode.

module aluctr_unit (
  input  logic       clock,
  input  logic       reset,
  input  logic [1:0] ALUOp,
  input  logic [5:0] func,
  output logic [2:0] ALUctr,
  output logic       illegal
);

  // ALU operation select codes; 011, 100 and 101 are never produced.
  typedef enum logic [2:0] {
    CTR_AND = 3'b000,
    CTR_OR  = 3'b001,
    CTR_ADD = 3'b010,
    CTR_SUB = 3'b110,
    CTR_SLT = 3'b111
  } alu_ctr_e;

  // Operation class coming from main control.
  typedef enum logic [1:0] {
    OP_MEM    = 2'b00,
    OP_BRANCH = 2'b01,
    OP_RTYPE  = 2'b10,
    OP_RSVD   = 2'b11
  } alu_op_e;

  alu_ctr_e ctr_next;
  logic     illegal_next;

  // Upper funct bits are don't-care for every instruction this block decodes.
  logic unused_func_hi;
  assign unused_func_hi = ^func[5:4];

  // Decode operation class and funct into the next ALU select and legality flag.
  always_comb begin
    // NOTE: every output of this block gets a default before the case, so no
    // path leaves a value unassigned and no latch is inferred.
    ctr_next     = CTR_ADD;
    illegal_next = 1'b0;
    case (alu_op_e'(ALUOp))
      OP_MEM:    ctr_next = CTR_ADD;
      OP_BRANCH: ctr_next = CTR_SUB;
      OP_RTYPE: begin
        case (func[3:0])
          4'b0000: ctr_next = CTR_ADD;
          4'b0010: ctr_next = CTR_SUB;
          4'b0100: ctr_next = CTR_AND;
          4'b0101: ctr_next = CTR_OR;
          4'b1010: ctr_next = CTR_SLT;
          default: begin
            ctr_next     = CTR_ADD;
            illegal_next = 1'b1;
          end
        endcase
      end
      OP_RSVD: begin
        ctr_next     = CTR_ADD;
        illegal_next = 1'b1;
      end
      default: begin
        ctr_next     = CTR_ADD;
        illegal_next = 1'b1;
      end
    endcase
  end

  // Output registers; synchronous reset wins over the decode on the same edge.
  always_ff @(posedge clock) begin
    // NOTE: state is updated with non-blocking assignments so every register
    // samples values from before the edge, independent of statement order.
    if (reset) begin
      ALUctr  <= CTR_AND;
      illegal <= 1'b0;
    end else begin
      ALUctr  <= ctr_next;
      illegal <= illegal_next;
    end
  end

endmodule

// File: tb/tb_aluctr_unit.sv
// Testbench for aluctr_unit: directed scenarios followed by random
// operation/funct/reset traffic compared against a table-driven model.

module tb_aluctr_unit;

  logic       clock;
  logic       reset;
  logic [1:0] ALUOp;
  logic [5:0] func;
  logic [2:0] ALUctr;
  logic       illegal;

  int passed = 0;
  int total  = 0;
  int failed = 0;

  // Expected register contents after the most recent edge.
  logic [2:0] exp_ctr;
  logic       exp_ill;

  // Legal R-type funct low nibbles and the ALU select each one requests.
  int         r_func [5] = '{0, 2, 4, 5, 10};
  logic [2:0] r_ctr  [5] = '{3'b010, 3'b110, 3'b000, 3'b001, 3'b111};

  aluctr_unit dut (
    .clock  (clock),
    .reset  (reset),
    .ALUOp  (ALUOp),
    .func   (func),
    .ALUctr (ALUctr),
    .illegal(illegal)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Reference: what the outputs must hold after an edge that samples these inputs.
  task automatic model(input logic rst, input logic [1:0] op, input logic [5:0] f,
                       output logic [2:0] ctr, output logic ill);
    int nib;
    bit hit;
    nib = int'(f) % 16;
    hit = 1'b0;
    ctr = 3'b010;
    ill = 1'b0;
    if (rst) begin
      ctr = 3'b000;
    end else if (op == 2'd0) begin
      ctr = 3'b010;
    end else if (op == 2'd1) begin
      ctr = 3'b110;
    end else if (op == 2'd2) begin
      for (int k = 0; k < 5; k++) begin
        if (r_func[k] == nib) begin
          ctr = r_ctr[k];
          hit = 1'b1;
        end
      end
      ill = !hit;
    end else begin
      ill = 1'b1;
    end
  endtask

  task automatic check(input string tag, input logic [2:0] obs, input logic [2:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  // Drive inputs away from the edge, clock once, then check both outputs.
  task automatic step(input string tag, input logic rst, input logic [1:0] op,
                      input logic [5:0] f);
    @(negedge clock);
    reset = rst;
    ALUOp = op;
    func  = f;
    model(rst, op, f, exp_ctr, exp_ill);
    @(posedge clock);
    #1;
    check({tag, ".ctr"}, ALUctr, exp_ctr);
    check({tag, ".ill"}, {2'b00, illegal}, {2'b00, exp_ill});
  endtask

  initial begin
    reset = 1'b1;
    ALUOp = 2'b10;
    func  = 6'b000010;

    // Reset held for two edges with an R-type SUB on the inputs.
    step("rst0", 1'b1, 2'b10, 6'b000010);
    check("rst0.const", ALUctr, 3'b000);
    step("rst1", 1'b1, 2'b10, 6'b000010);
    step("rst_rel", 1'b0, 2'b10, 6'b000010);
    check("rst_rel.const", ALUctr, 3'b110);

    // Load/store and branch classes.
    step("mem", 1'b0, 2'b00, 6'b000000);
    step("br", 1'b0, 2'b01, 6'b000000);
    step("mem_f", 1'b0, 2'b00, 6'b111111);
    step("br_f", 1'b0, 2'b01, 6'b101011);

    // Every legal R-type funct.
    step("r_add", 1'b0, 2'b10, 6'b000000);
    step("r_sub", 1'b0, 2'b10, 6'b000010);
    step("r_and", 1'b0, 2'b10, 6'b000100);
    step("r_or", 1'b0, 2'b10, 6'b000101);
    step("r_slt", 1'b0, 2'b10, 6'b001010);

    // Upper funct bits ignored.
    step("hi_or", 1'b0, 2'b10, 6'b100101);
    check("hi_or.const", ALUctr, 3'b001);
    step("lo_or", 1'b0, 2'b10, 6'b000101);
    step("hi_add", 1'b0, 2'b10, 6'b100000);

    // Unsupported combinations, then recovery.
    step("r_bad", 1'b0, 2'b10, 6'b000111);
    check("r_bad.const", {2'b00, illegal}, 3'b001);
    step("rsvd", 1'b0, 2'b11, 6'b000000);
    step("rsvd_f", 1'b0, 2'b11, 6'b000010);
    step("recover", 1'b0, 2'b00, 6'b000000);

    // Held inputs keep the outputs constant.
    step("hold0", 1'b0, 2'b10, 6'b001010);
    step("hold1", 1'b0, 2'b10, 6'b001010);

    // Mid-cycle input wiggle returned before the edge: no effect in between.
    @(negedge clock);
    ALUOp = 2'b11;
    func  = 6'b000111;
    #1;
    check("glitch.mid_ctr", ALUctr, exp_ctr);
    check("glitch.mid_ill", {2'b00, illegal}, {2'b00, exp_ill});
    ALUOp = 2'b10;
    func  = 6'b000100;
    model(1'b0, 2'b10, 6'b000100, exp_ctr, exp_ill);
    @(posedge clock);
    #1;
    check("glitch.edge_ctr", ALUctr, exp_ctr);
    check("glitch.edge_ill", {2'b00, illegal}, {2'b00, exp_ill});

    // Reset pulsed between edges does nothing.
    @(negedge clock);
    reset = 1'b1;
    #1;
    check("rst_mid.hold", ALUctr, exp_ctr);
    reset = 1'b0;
    ALUOp = 2'b01;
    model(1'b0, 2'b01, func, exp_ctr, exp_ill);
    @(posedge clock);
    #1;
    check("rst_mid.edge", ALUctr, exp_ctr);

    // Random traffic with occasional reset.
    for (int i = 0; i < 300; i++) begin
      step($sformatf("rnd%0d", i), ($urandom_range(0, 15) == 0),
           2'($urandom_range(0, 3)), 6'($urandom_range(0, 63)));
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
